// File: rtl/moving_avg_filter_pkg.sv
// Shared types and defaults for the moving-average filter stage.
package moving_avg_filter_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_LOG_WIN   = 2;
  localparam int DEF_FRAME_LEN = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/moving_avg_filter_if.sv
// Control/sample/result bundle between control_fsm, the filter and the compare stage.
interface moving_avg_filter_if
  import moving_avg_filter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic                     filter_enable;
  logic signed [DATA_W-1:0] sample_in;
  logic                     sample_valid;
  logic                     sample_ready;
  logic signed [DATA_W-1:0] filtered_out;
  logic                     filtered_valid;
  logic                     filter_done;

  // Upstream side: drives the job permission and samples, observes results.
  modport master (
    output filter_enable, sample_in, sample_valid,
    input  sample_ready, filtered_out, filtered_valid, filter_done
  );

  // Filter side.
  modport slave (
    input  filter_enable, sample_in, sample_valid,
    output sample_ready, filtered_out, filtered_valid, filter_done
  );
endinterface

// File: rtl/moving_avg_filter_delay_line.sv
// avg_delay_line: WIN-deep sample shift register; newest enters tap 0,
// oldest tap is exposed so the accumulator can subtract it.
module moving_avg_filter_delay_line #(
  parameter int DATA_W = 8,
  parameter int WIN    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] oldest
);
  logic [WIN-1:0][DATA_W-1:0] taps;

  // Shift on load; clear zero-fills so a new frame starts from partial averages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      taps <= '0;
    else if (clear) taps <= '0;
    else if (load)  taps <= {taps[WIN-2:0], din};
  end

  assign oldest = $signed(taps[WIN-1]);
endmodule

// File: rtl/moving_avg_filter.sv
// Boxcar average over the last 2^LOG_WIN samples of a FRAME_LEN-sample frame,
// with a job handshake (filter_enable in, filter_done pulse out).
module moving_avg_filter
  import moving_avg_filter_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LOG_WIN   = DEF_LOG_WIN,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input logic                 clk,
  input logic                 reset,
  moving_avg_filter_if.slave  bus
);
  localparam int WIN   = 1 << LOG_WIN;
  localparam int SUM_W = DATA_W + LOG_WIN;
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t                    state, state_nxt;
  logic                      accept, dl_clear, dl_load;
  logic                      last_accept;
  logic [CNT_W-1:0]          count;
  logic signed [SUM_W-1:0]   sum, sum_nxt, avg_full;
  logic signed [DATA_W-1:0]  oldest;

  // Running sum: add the new sample, drop the one leaving the window.
  // SUM_W bits hold WIN full-scale samples, so no overflow is possible.
  assign sum_nxt     = sum + SUM_W'(bus.sample_in) - SUM_W'(oldest);
  assign avg_full    = sum_nxt >>> LOG_WIN;
  assign last_accept = accept && (count == LAST_CNT);

  moving_avg_filter_delay_line #(
    .DATA_W (DATA_W),
    .WIN    (WIN)
  ) u_dly (
    .clk    (clk),
    .reset  (reset),
    .clear  (dl_clear),
    .load   (dl_load),
    .din    (bus.sample_in),
    .oldest (oldest)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; dropping enable aborts CLEAR/RUN, but never a DONE in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.filter_enable) state_nxt = CLEAR;
      CLEAR:   state_nxt = bus.filter_enable ? RUN : IDLE;
      RUN: begin
        if (!bus.filter_enable) state_nxt = IDLE;
        else if (last_accept)   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded controls; sample_ready is the only combinational output.
  always_comb begin
    bus.sample_ready = (state == RUN);
    accept           = bus.sample_valid && (state == RUN);
    dl_clear         = (state == CLEAR);
    dl_load          = accept;
  end

  // Accumulator and frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum   <= '0;
      count <= '0;
    end else if (state == CLEAR) begin
      sum   <= '0;
      count <= '0;
    end else if (accept) begin
      sum   <= sum_nxt;
      count <= count + 1'b1;
    end
  end

  // Registered results; filtered_out holds its last value between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.filtered_out   <= '0;
      bus.filtered_valid <= 1'b0;
      bus.filter_done    <= 1'b0;
    end else begin
      bus.filtered_valid <= accept;
      bus.filter_done    <= (state == DONE);
      if (accept) bus.filtered_out <= avg_full[DATA_W-1:0];
    end
  end
endmodule

// File: tb/tb_moving_avg_filter.sv
// Bench for moving_avg_filter: transaction-level reference model, per-cycle
// compare process, directed frames with literal expectations, then random traffic.
module tb_moving_avg_filter;
  localparam int DATA_W    = 8;
  localparam int LOG_WIN   = 2;
  localparam int WIN       = 1 << LOG_WIN;
  localparam int FRAME_LEN = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  moving_avg_filter_if #(.DATA_W(DATA_W)) bus();

  moving_avg_filter #(
    .DATA_W    (DATA_W),
    .LOG_WIN   (LOG_WIN),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int obs_q[$];
  int done_cnt    = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Floor division by the window length (rounds toward -inf).
  function automatic int fdiv(input int s);
    int q;
    q = s / WIN;
    if (s < 0 && q * WIN != s) q--;
    return q;
  endfunction

  // Reference model: phase 0 idle, 1 clear, 2 run, 3 done.
  // Window kept as a queue of accepted samples; average recomputed from scratch.
  int phase   = 0;
  int win_q[$];
  int m_cnt   = 0;
  int exp_fo  = 0;
  bit exp_fv  = 1'b0;
  bit exp_dn  = 1'b0;
  bit exp_rdy = 1'b0;
  bit m_acc   = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase = 0; win_q.delete(); m_cnt = 0;
      exp_fo = 0; exp_fv = 1'b0; exp_dn = 1'b0; exp_rdy = 1'b0;
    end else begin : upd
      int s;
      exp_dn = (phase == 3);
      exp_fv = 1'b0;
      m_acc  = (phase == 2) && bus.sample_valid;
      if (m_acc) begin
        win_q.push_front(int'(bus.sample_in));
        if (win_q.size() > WIN) void'(win_q.pop_back());
        s = 0;
        foreach (win_q[k]) s += win_q[k];
        exp_fo = fdiv(s);
        exp_fv = 1'b1;
        m_cnt++;
      end
      case (phase)
        0: if (bus.filter_enable) phase = 1;
        1: begin
          win_q.delete(); m_cnt = 0;
          phase = bus.filter_enable ? 2 : 0;
        end
        2: if (!bus.filter_enable) phase = 0;
           else if (m_acc && m_cnt == FRAME_LEN) phase = 3;
        default: phase = 0;
      endcase
      exp_rdy = (phase == 2);
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("sample_ready",   int'(bus.sample_ready),   int'(exp_rdy));
    chk("filtered_valid", int'(bus.filtered_valid), int'(exp_fv));
    chk("filter_done",    int'(bus.filter_done),    int'(exp_dn));
    chk("filtered_out",   int'(bus.filtered_out),   exp_fo);
    if (bus.filtered_valid) obs_q.push_back(int'(bus.filtered_out));
    if (bus.filter_done)    done_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic start();
    obs_q.delete();
    done_cnt = 0;
  endtask

  // kind 0: constant base, 1: ramp base+i, 2: random. Stops after n accepts.
  task automatic feed(input int kind, input int base, input int n, input bit toggle);
    int i = 0;
    int guard = 0;
    bit acc;
    bit tog = 1'b1;
    while (i < n && guard < 400) begin
      bus.sample_valid = toggle ? tog : 1'b1;
      tog = ~tog;
      case (kind)
        0:       bus.sample_in = DATA_W'(base);
        1:       bus.sample_in = DATA_W'(base + i);
        default: bus.sample_in = DATA_W'($urandom);
      endcase
      acc = bus.sample_valid && bus.sample_ready;
      @(posedge clk); #2;
      if (acc) i++;
      guard++;
    end
    bus.sample_valid = 1'b0;
    if (i < n) chk("feed_timeout", i, n);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.filter_enable = 1'b0;
    bus.sample_valid  = 1'b0;
    bus.sample_in     = '0;
    cycles(3);
    chk("reset_out",   int'(bus.filtered_out), 0);
    chk("reset_ready", int'(bus.sample_ready), 0);
    reset = 1'b0;
    cycles(2);

    // Constant 8.
    start(); bus.filter_enable = 1'b1;
    feed(0, 8, FRAME_LEN, 1'b0);
    bus.filter_enable = 1'b0; cycles(4);
    chk("c8_count", obs_q.size(), 16);
    chk("c8_o0", obs_q[0], 2); chk("c8_o1", obs_q[1], 4);
    chk("c8_o2", obs_q[2], 6); chk("c8_o3", obs_q[3], 8);
    chk("c8_o15", obs_q[15], 8);
    chk("c8_done", done_cnt, 1);

    // Constant -4: floor shift.
    start(); bus.filter_enable = 1'b1;
    feed(0, -4, FRAME_LEN, 1'b0);
    bus.filter_enable = 1'b0; cycles(4);
    chk("cm4_o0", obs_q[0], -1); chk("cm4_o1", obs_q[1], -2);
    chk("cm4_o2", obs_q[2], -3); chk("cm4_o3", obs_q[3], -4);
    chk("cm4_o12", obs_q[12], -4);
    chk("cm4_done", done_cnt, 1);

    // Ramp 0..15 with toggling valid.
    start(); bus.filter_enable = 1'b1;
    feed(1, 0, FRAME_LEN, 1'b1);
    bus.filter_enable = 1'b0; cycles(4);
    chk("ramp_count", obs_q.size(), 16);
    chk("ramp_o2", obs_q[2], 0); chk("ramp_o3", obs_q[3], 1);
    chk("ramp_o15", obs_q[15], 13);
    chk("ramp_done", done_cnt, 1);

    // Sticky enable: two frames back-to-back.
    start(); bus.filter_enable = 1'b1;
    feed(0, 8, FRAME_LEN, 1'b0);
    feed(0, 8, FRAME_LEN, 1'b0);
    bus.filter_enable = 1'b0; cycles(4);
    chk("sticky_count", obs_q.size(), 32);
    chk("sticky_o16", obs_q[16], 2);
    chk("sticky_o19", obs_q[19], 8);
    chk("sticky_done", done_cnt, 2);

    // Abort after 5 accepts, then a fresh frame.
    start(); bus.filter_enable = 1'b1;
    feed(0, 8, 5, 1'b0);
    bus.filter_enable = 1'b0; cycles(3);
    chk("abort_count", obs_q.size(), 5);
    chk("abort_done", done_cnt, 0);
    start(); bus.filter_enable = 1'b1;
    feed(0, 8, FRAME_LEN, 1'b0);
    bus.filter_enable = 1'b0; cycles(4);
    chk("reen_o0", obs_q[0], 2);
    chk("reen_done", done_cnt, 1);

    // Reset after 7 accepts.
    start(); bus.filter_enable = 1'b1;
    feed(0, 8, 7, 1'b0);
    reset = 1'b1; #1;
    chk("midrst_out",   int'(bus.filtered_out), 0);
    chk("midrst_valid", int'(bus.filtered_valid), 0);
    chk("midrst_ready", int'(bus.sample_ready), 0);
    cycles(2);
    reset = 1'b0; start();
    feed(0, 8, FRAME_LEN, 1'b0);
    bus.filter_enable = 1'b0; cycles(4);
    chk("postrst_o0", obs_q[0], 2);
    chk("postrst_o3", obs_q[3], 8);
    chk("postrst_count", obs_q.size(), 16);
    chk("postrst_done", done_cnt, 1);

    // Random traffic: random samples, valid and occasional enable drops.
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 60; c++) begin
        bus.filter_enable = ($urandom_range(0, 39) != 0);
        bus.sample_valid  = ($urandom_range(0, 9) < 7);
        bus.sample_in     = DATA_W'($urandom);
        cycles(1);
      end
      bus.filter_enable = 1'b0;
      bus.sample_valid  = 1'b0;
      cycles(4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
